// File: rtl/axi_tb_pkg.sv
// Shared types for the AXI4 bench memory: burst encodings, response codes
// and the state sets of the independent write and read channel FSMs.
package axi_tb_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rstate_e;

endpackage

// File: rtl/axi_tb_burst_addr.sv
// Combinational AXI burst address step: given the current beat address and
// the burst descriptor, produce the next beat address and flag descriptors
// that this memory answers with SLVERR.
module axi_tb_burst_addr
    import axi_tb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              err_o
);
    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] align_mask;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;
    logic              wrap_len_ok;
    logic              size_err;

    assign step        = ADDR_W'(1) << size_i;
    assign align_mask  = step - ADDR_W'(1);
    // Wrap block is (len+1) beats of 2^size bytes; only power-of-two lengths are legal.
    assign wrap_mask   = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
    assign incr_addr   = (addr_i & ~align_mask) + step;
    assign wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    assign size_err    = (int'(size_i) > MAX_SIZE);

    // Select next address by burst type; illegal descriptors fall back to INCR.
    always_comb begin
        next_addr_o = incr_addr;
        err_o       = size_err;
        case (burst_e'(burst_i))
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr_addr;
            BURST_WRAP: begin
                if (wrap_len_ok) begin
                    next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);
                end else begin
                    err_o = 1'b1;
                end
            end
            default:     err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_tb_mem.sv
// AXI4 slave memory model for simulation benches: independent write and read
// channels with FIXED/INCR/WRAP bursts, SLVERR reporting, and MMIO console
// and halt registers. The array "mem" is word-indexed so benches can preload it.
module axi_tb_mem
    import axi_tb_pkg::*;
#(
    parameter int                ID_W         = 4,
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 64,
    parameter int unsigned       MEM_BYTES    = 32'h100_0000,
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(32'h1000_0000),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(32'h2000_0000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [ID_W-1:0]     aw_id,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [7:0]          aw_len,
    input  logic [2:0]          aw_size,
    input  logic [1:0]          aw_burst,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_last,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [ID_W-1:0]     b_id,
    output logic [1:0]          b_resp,
    input  logic                ar_valid,
    output logic                ar_ready,
    input  logic [ID_W-1:0]     ar_id,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic [7:0]          ar_len,
    input  logic [2:0]          ar_size,
    input  logic [1:0]          ar_burst,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [ID_W-1:0]     r_id,
    output logic [DATA_W-1:0]   r_data,
    output logic [1:0]          r_resp,
    output logic                r_last,
    output logic                console_valid,
    output logic [7:0]          console_char,
    output logic                halt_valid,
    output logic [31:0]         halt_code
);
    localparam int                STRB_W    = DATA_W / 8;
    localparam int                OFF_W     = $clog2(STRB_W);
    localparam int                IDX_W     = $clog2(MEM_BYTES);
    localparam int                WORDS     = MEM_BYTES / STRB_W;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(STRB_W - 1);

    logic [DATA_W-1:0] mem [0:WORDS-1];

    // Lowest enabled byte lane carries the console character.
    function automatic logic [7:0] low_lane(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        logic [7:0] c;
        c = 8'h00;
        for (int i = STRB_W - 1; i >= 0; i--) begin
            if (s[i]) c = d[8*i +: 8];
        end
        return c;
    endfunction

    // ---------------- write channel ----------------
    wstate_e           wstate_q, wstate_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, waddr_next;
    logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              werr_q, werr_d, waddr_err, w_last_exp, w_is_con, w_is_halt, mem_we;
    logic              console_valid_q, console_valid_d, halt_valid_q, halt_valid_d;
    logic [7:0]        console_char_q, console_char_d;
    logic [31:0]       halt_code_q, halt_code_d;

    axi_tb_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_waddr (
        .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q), .burst_i(wburst_q),
        .next_addr_o(waddr_next), .err_o(waddr_err)
    );

    assign aw_ready   = (wstate_q == W_IDLE) && !rst;
    assign w_ready    = (wstate_q == W_DATA);
    assign b_valid    = (wstate_q == W_RESP);
    assign b_id       = aw_id_q;
    assign b_resp     = werr_q ? RESP_SLVERR : RESP_OKAY;
    assign w_last_exp = (wbeat_q == wlen_q);
    assign w_is_con   = ((waddr_q & WORD_MASK) == CONSOLE_ADDR);
    assign w_is_halt  = ((waddr_q & WORD_MASK) == HALT_ADDR);

    // Write FSM next state: accept AW, sink len+1 beats, hold B until taken.
    always_comb begin
        wstate_d        = wstate_q;
        aw_id_d         = aw_id_q;
        waddr_d         = waddr_q;
        wlen_d          = wlen_q;
        wsize_d         = wsize_q;
        wburst_d        = wburst_q;
        wbeat_d         = wbeat_q;
        werr_d          = werr_q;
        console_valid_d = 1'b0;
        console_char_d  = console_char_q;
        halt_valid_d    = 1'b0;
        halt_code_d     = halt_code_q;
        mem_we          = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_valid && aw_ready) begin
                    aw_id_d  = aw_id;
                    waddr_d  = aw_addr;
                    wlen_d   = aw_len;
                    wsize_d  = aw_size;
                    wburst_d = aw_burst;
                    wbeat_d  = 8'd0;
                    werr_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_valid) begin
                    werr_d  = werr_q | waddr_err | (w_last != w_last_exp);
                    waddr_d = waddr_next;
                    wbeat_d = wbeat_q + 8'd1;
                    if (w_is_con) begin
                        console_valid_d = 1'b1;
                        console_char_d  = low_lane(w_data, w_strb);
                    end else if (w_is_halt) begin
                        halt_valid_d = 1'b1;
                        halt_code_d  = w_data[31:0];
                    end else begin
                        mem_we = 1'b1;
                    end
                    if (w_last_exp) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write channel control and visible outputs; reset aborts any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q        <= W_IDLE;
            aw_id_q         <= '0;
            werr_q          <= 1'b0;
            console_valid_q <= 1'b0;
            console_char_q  <= 8'h00;
            halt_valid_q    <= 1'b0;
            halt_code_q     <= 32'h0;
        end else begin
            wstate_q        <= wstate_d;
            aw_id_q         <= aw_id_d;
            werr_q          <= werr_d;
            console_valid_q <= console_valid_d;
            console_char_q  <= console_char_d;
            halt_valid_q    <= halt_valid_d;
            halt_code_q     <= halt_code_d;
        end
    end

    // Write burst descriptor and beat tracking (no reset needed).
    always_ff @(posedge clk) begin
        waddr_q  <= waddr_d;
        wlen_q   <= wlen_d;
        wsize_q  <= wsize_d;
        wburst_q <= wburst_d;
        wbeat_q  <= wbeat_d;
    end

    // Byte-strobed memory write; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) mem[waddr_q[IDX_W-1:OFF_W]][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    assign console_valid = console_valid_q;
    assign console_char  = console_char_q;
    assign halt_valid    = halt_valid_q;
    assign halt_code     = halt_code_q;

    // ---------------- read channel ----------------
    rstate_e           rstate_q, rstate_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, raddr_next;
    logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d, r_resp_q, r_resp_d;
    logic              r_last_q, r_last_d, raddr_err, r_fetch, r_is_mmio;
    logic [DATA_W-1:0] r_data_q;

    axi_tb_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_raddr (
        .addr_i(raddr_q), .len_i(rlen_q), .size_i(rsize_q), .burst_i(rburst_q),
        .next_addr_o(raddr_next), .err_o(raddr_err)
    );

    assign ar_ready  = (rstate_q == R_IDLE) && !rst;
    assign r_valid   = (rstate_q == R_DATA);
    assign r_id      = ar_id_q;
    assign r_data    = r_data_q;
    assign r_resp    = r_resp_q;
    assign r_last    = r_last_q;
    assign r_is_mmio = ((raddr_q & WORD_MASK) == CONSOLE_ADDR) || ((raddr_q & WORD_MASK) == HALT_ADDR);

    // Read FSM next state: fetch one word, present it until taken, repeat.
    always_comb begin
        rstate_d = rstate_q;
        ar_id_d  = ar_id_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rsize_d  = rsize_q;
        rburst_d = rburst_q;
        rbeat_d  = rbeat_q;
        r_resp_d = r_resp_q;
        r_last_d = r_last_q;
        r_fetch  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (ar_valid && ar_ready) begin
                    ar_id_d  = ar_id;
                    raddr_d  = ar_addr;
                    rlen_d   = ar_len;
                    rsize_d  = ar_size;
                    rburst_d = ar_burst;
                    rbeat_d  = 8'd0;
                    rstate_d = R_FETCH;
                end
            end
            R_FETCH: begin
                r_fetch  = 1'b1;
                r_resp_d = raddr_err ? RESP_SLVERR : RESP_OKAY;
                r_last_d = (rbeat_q == rlen_q);
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (r_ready) begin
                    if (r_last_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        raddr_d  = raddr_next;
                        rbeat_d  = rbeat_q + 8'd1;
                        rstate_d = R_FETCH;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read channel control and response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            ar_id_q  <= '0;
            r_resp_q <= 2'b00;
            r_last_q <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            ar_id_q  <= ar_id_d;
            r_resp_q <= r_resp_d;
            r_last_q <= r_last_d;
        end
    end

    // Read burst descriptor and beat tracking (no reset needed).
    always_ff @(posedge clk) begin
        raddr_q  <= raddr_d;
        rlen_q   <= rlen_d;
        rsize_q  <= rsize_d;
        rburst_q <= rburst_d;
        rbeat_q  <= rbeat_d;
    end

    // Registered memory read; MMIO locations read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
        end else if (r_fetch) begin
            r_data_q <= r_is_mmio ? '0 : mem[raddr_q[IDX_W-1:OFF_W]];
        end
    end

endmodule
